axi4_a23_wbuf: RTL and testbench

Posted-write buffer between the Amber core execute-stage memory port and the AXI4 master interface block (axi4_a23_axi_if).
- Absorbs ordinary core writes into an in-order FIFO and acknowledges them at once.
- Drains buffered writes to the master interface one at a time.
- Reads and exclusive (swap) accesses pass through only once the buffer is empty, so memory ordering is preserved.

---
 rtl/axi4_a23_wbuf.sv | 183 ++++++++++++++++++
 tb/tb_axi4_a23_wbuf.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_a23_wbuf.sv
// Posted-write buffer between the Amber execute-stage memory port and the
// AXI4 master interface. Ordinary writes are queued and acknowledged at once;
// reads and exclusive accesses wait for the queue to drain, then pass through.
`timescale 1ns/1ps

module axi4_a23_wbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_select,
    input  logic              i_write_enable,
    input  logic [DW/8-1:0]   i_byte_enable,
    input  logic [DW-1:0]     i_write_data,
    input  logic [AW-1:0]     i_address,
    input  logic              i_data_access,
    input  logic              i_exclusive,
    output logic              o_stall,
    output logic              o_ack,
    output logic [DW-1:0]     o_read_data,
    output logic              o_dabt,
    output logic              o_select,
    output logic              o_write_enable,
    output logic [DW/8-1:0]   o_byte_enable,
    output logic [DW-1:0]     o_write_data,
    output logic [AW-1:0]     o_address,
    output logic              o_data_access,
    output logic              o_exclusive,
    input  logic              i_stall,
    input  logic              i_ack,
    input  logic [DW-1:0]     i_read_data,
    input  logic              i_dabt,
    output logic              o_werr,
    input  logic              i_werr_clr,
    output logic              o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = DW / 8;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WR, PT} state_t;

    state_t          state;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;

    logic [AW-1:0]   mem_addr [DEPTH];
    logic [DW-1:0]   mem_data [DEPTH];
    logic [BW-1:0]   mem_be   [DEPTH];
    logic            mem_da   [DEPTH];

    logic            buf_wr_req;
    logic            pt_req;
    logic            full;
    logic            push;
    logic            pop;

    // Completion is signalled by i_ack alone; the busy flag carries no extra
    // information for a single-outstanding-access buffer.
    logic            unused_stall;
    assign unused_stall = i_stall;

    // Request classification and queue bookkeeping. Pushes are refused while a
    // pass-through is being forwarded so the same request is never sent twice.
    always_comb begin
        buf_wr_req = i_select & i_write_enable & ~i_exclusive;
        pt_req     = i_select & ~buf_wr_req;
        full       = (count == FULL_COUNT);
        push       = buf_wr_req & ~full & (state != PT);
        pop        = (state == WR) & i_ack;
        count_next = count + CW'(push) - CW'(pop);
        o_empty    = (count == '0);
    end

    // Downstream request mux and core-side handshake.
    always_comb begin
        o_select       = 1'b0;
        o_write_enable = 1'b0;
        o_byte_enable  = '0;
        o_write_data   = '0;
        o_address      = '0;
        o_data_access  = 1'b0;
        o_exclusive    = 1'b0;
        o_ack          = 1'b0;
        o_stall        = 1'b0;
        o_read_data    = '0;
        o_dabt         = 1'b0;

        case (state)
            WR: begin
                o_select       = 1'b1;
                o_write_enable = 1'b1;
                o_byte_enable  = mem_be[rd_ptr];
                o_write_data   = mem_data[rd_ptr];
                o_address      = mem_addr[rd_ptr];
                o_data_access  = mem_da[rd_ptr];
            end
            PT: begin
                o_select       = 1'b1;
                o_write_enable = i_write_enable;
                o_byte_enable  = i_byte_enable;
                o_write_data   = i_write_data;
                o_address      = i_address;
                o_data_access  = i_data_access;
                o_exclusive    = i_exclusive;
            end
            default: begin
            end
        endcase

        if (push) begin
            o_ack = 1'b1;
        end else if (buf_wr_req) begin
            o_stall = 1'b1;
        end else if (pt_req) begin
            if (state == PT) begin
                o_ack       = i_ack;
                o_stall     = ~i_ack;
                o_read_data = i_read_data;
                o_dabt      = i_dabt;
            end else begin
                o_stall = 1'b1;
            end
        end
    end

    // Queue storage, pointers, sticky write error and drain/pass-through FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            o_werr <= 1'b0;
        end else begin
            if (push) begin
                mem_addr[wr_ptr] <= i_address;
                mem_data[wr_ptr] <= i_write_data;
                mem_be[wr_ptr]   <= i_byte_enable;
                mem_da[wr_ptr]   <= i_data_access;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;

            if (pop && i_dabt) begin
                o_werr <= 1'b1;
            end else if (i_werr_clr) begin
                o_werr <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= WR;
                    end else if (pt_req) begin
                        state <= PT;
                    end
                end
                WR: begin
                    if (pop) begin
                        state <= (count_next != '0) ? WR : IDLE;
                    end
                end
                PT: begin
                    if (i_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_a23_wbuf.sv
// Self-checking bench for axi4_a23_wbuf: a table of single-cycle handshake
// vectors from the empty state, then hand-written multi-cycle sequences.
`timescale 1ns/1ps

module tb_axi4_a23_wbuf;

    logic        i_clk;
    logic        i_rst;
    logic        i_select;
    logic        i_write_enable;
    logic [3:0]  i_byte_enable;
    logic [31:0] i_write_data;
    logic [31:0] i_address;
    logic        i_data_access;
    logic        i_exclusive;
    logic        o_stall;
    logic        o_ack;
    logic [31:0] o_read_data;
    logic        o_dabt;
    logic        o_select;
    logic        o_write_enable;
    logic [3:0]  o_byte_enable;
    logic [31:0] o_write_data;
    logic [31:0] o_address;
    logic        o_data_access;
    logic        o_exclusive;
    logic        i_stall;
    logic        i_ack;
    logic [31:0] i_read_data;
    logic        i_dabt;
    logic        o_werr;
    logic        i_werr_clr;
    logic        o_empty;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic sel;
        logic we;
        logic excl;
        logic da;
        logic exp_ack;
        logic exp_stall;
    } vec_t;

    vec_t vecs [5];

    logic [31:0] drain_addr [4];
    logic [31:0] drain_data [4];

    axi4_a23_wbuf #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_select       (i_select),
        .i_write_enable (i_write_enable),
        .i_byte_enable  (i_byte_enable),
        .i_write_data   (i_write_data),
        .i_address      (i_address),
        .i_data_access  (i_data_access),
        .i_exclusive    (i_exclusive),
        .o_stall        (o_stall),
        .o_ack          (o_ack),
        .o_read_data    (o_read_data),
        .o_dabt         (o_dabt),
        .o_select       (o_select),
        .o_write_enable (o_write_enable),
        .o_byte_enable  (o_byte_enable),
        .o_write_data   (o_write_data),
        .o_address      (o_address),
        .o_data_access  (o_data_access),
        .o_exclusive    (o_exclusive),
        .i_stall        (i_stall),
        .i_ack          (i_ack),
        .i_read_data    (i_read_data),
        .i_dabt         (i_dabt),
        .o_werr         (o_werr),
        .i_werr_clr     (i_werr_clr),
        .o_empty        (o_empty)
    );

    // 100 MHz clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Hard stop in case a sequence never completes
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_core();
        i_select       = 1'b0;
        i_write_enable = 1'b0;
        i_exclusive    = 1'b0;
        i_data_access  = 1'b0;
        i_byte_enable  = 4'h0;
        i_write_data   = 32'h0;
        i_address      = 32'h0;
    endtask

    task automatic apply_stimulus(input logic sel, input logic we, input logic excl,
                                  input logic da, input logic [31:0] addr, input logic [31:0] data);
        i_select       = sel;
        i_write_enable = we;
        i_exclusive    = excl;
        i_data_access  = da;
        i_byte_enable  = 4'hF;
        i_address      = addr;
        i_write_data   = data;
    endtask

    initial begin
        vecs[0] = '{sel:1'b1, we:1'b1, excl:1'b0, da:1'b1, exp_ack:1'b1, exp_stall:1'b0};
        vecs[1] = '{sel:1'b1, we:1'b1, excl:1'b0, da:1'b0, exp_ack:1'b1, exp_stall:1'b0};
        vecs[2] = '{sel:1'b1, we:1'b0, excl:1'b0, da:1'b1, exp_ack:1'b0, exp_stall:1'b1};
        vecs[3] = '{sel:1'b1, we:1'b1, excl:1'b1, da:1'b1, exp_ack:1'b0, exp_stall:1'b1};
        vecs[4] = '{sel:1'b0, we:1'b0, excl:1'b0, da:1'b1, exp_ack:1'b0, exp_stall:1'b0};

        drain_addr[0] = 32'h104; drain_data[0] = 32'h22222222;
        drain_addr[1] = 32'h108; drain_data[1] = 32'h33333333;
        drain_addr[2] = 32'h10C; drain_data[2] = 32'h44444444;
        drain_addr[3] = 32'h110; drain_data[3] = 32'h55555555;

        clear_core();
        i_rst       = 1'b1;
        i_stall     = 1'b0;
        i_ack       = 1'b0;
        i_read_data = 32'h0;
        i_dabt      = 1'b0;
        i_werr_clr  = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        #1;

        // Reset state
        check_output("rst_empty",  o_empty,  1);
        check_output("rst_werr",   o_werr,   0);
        check_output("rst_select", o_select, 0);
        check_output("rst_ack",    o_ack,    0);
        check_output("rst_stall",  o_stall,  0);
        check_output("rst_count",  32'(dut.count), 0);

        // Handshake vectors from the empty idle state; inputs drop before the edge
        for (int v = 0; v < 5; v++) begin
            apply_stimulus(vecs[v].sel, vecs[v].we, vecs[v].excl, vecs[v].da, 32'h80 + 32'(v), 32'hA5A5_0000);
            #1;
            check_output($sformatf("vec%0d_ack", v),    o_ack,    vecs[v].exp_ack);
            check_output($sformatf("vec%0d_stall", v),  o_stall,  vecs[v].exp_stall);
            check_output($sformatf("vec%0d_select", v), o_select, 0);
            clear_core();
            tick();
        end
        check_output("vec_count", 32'(dut.count), 0);

        // Three back-to-back writes with downstream busy and no ack
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1, 1, 0, 1, 32'h100 + 32'(4 * k), 32'h11111111 * 32'(k + 1));
            #1;
            check_output($sformatf("w%0d_ack", k),   o_ack,   1);
            check_output($sformatf("w%0d_stall", k), o_stall, 0);
            tick();
        end
        clear_core();
        check_output("w3_count",  32'(dut.count), 3);
        check_output("w3_select", o_select, 1);
        check_output("w3_addr",   o_address, 32'h100);
        check_output("w3_data",   o_write_data, 32'h11111111);
        tick();
        tick();
        check_output("w3_addr_held", o_address, 32'h100);

        // Fill to DEPTH, then a fifth write stalls until a pop frees a slot
        apply_stimulus(1, 1, 0, 1, 32'h10C, 32'h44444444);
        #1;
        check_output("w4_ack", o_ack, 1);
        tick();
        check_output("w4_count", 32'(dut.count), 4);
        apply_stimulus(1, 1, 0, 1, 32'h110, 32'h55555555);
        #1;
        check_output("w5_stall_full", o_stall, 1);
        check_output("w5_ack_full",   o_ack,   0);
        i_ack = 1'b1;
        #1;
        check_output("w5_stall_pop", o_stall, 1);
        check_output("w5_ack_pop",   o_ack,   0);
        tick();
        i_ack = 1'b0;
        #1;
        check_output("w5_ack_next", o_ack, 1);
        tick();
        clear_core();
        check_output("w5_count", 32'(dut.count), 4);
        i_stall = 1'b0;

        // Drain in acceptance order
        for (int k = 0; k < 4; k++) begin
            #1;
            check_output($sformatf("drain%0d_sel", k),  o_select, 1);
            check_output($sformatf("drain%0d_we", k),   o_write_enable, 1);
            check_output($sformatf("drain%0d_addr", k), o_address, drain_addr[k]);
            check_output($sformatf("drain%0d_data", k), o_write_data, drain_data[k]);
            i_ack = 1'b1;
            tick();
            i_ack = 1'b0;
        end
        #1;
        check_output("drain_empty",  o_empty,  1);
        check_output("drain_select", o_select, 0);

        // Read behind two buffered writes
        apply_stimulus(1, 1, 0, 1, 32'h120, 32'h77777777);
        tick();
        apply_stimulus(1, 1, 0, 1, 32'h124, 32'h88888888);
        tick();
        apply_stimulus(1, 0, 0, 1, 32'h200, 32'h0);
        #1;
        check_output("rd_stall_w0", o_stall, 1);
        check_output("rd_addr_w0",  o_address, 32'h120);
        check_output("rd_we_w0",    o_write_enable, 1);
        i_ack = 1'b1;
        tick();
        check_output("rd_stall_w1", o_stall, 1);
        check_output("rd_ack_w1",   o_ack, 0);
        check_output("rd_addr_w1",  o_address, 32'h124);
        tick();
        i_ack = 1'b0;
        #1;
        check_output("rd_stall_idle", o_stall, 1);
        check_output("rd_sel_idle",   o_select, 0);
        check_output("rd_empty_idle", o_empty, 1);
        tick();
        i_read_data = 32'hDEADBEEF;
        #1;
        check_output("rd_pt_sel",   o_select, 1);
        check_output("rd_pt_we",    o_write_enable, 0);
        check_output("rd_pt_addr",  o_address, 32'h200);
        check_output("rd_pt_stall", o_stall, 1);
        i_ack = 1'b1;
        #1;
        check_output("rd_pt_ack",   o_ack, 1);
        check_output("rd_pt_data",  o_read_data, 32'hDEADBEEF);
        check_output("rd_pt_nostall", o_stall, 0);
        tick();
        i_ack = 1'b0;
        i_read_data = 32'h0;
        clear_core();

        // Swap at 0x300 with an empty buffer
        apply_stimulus(1, 0, 1, 1, 32'h300, 32'h0);
        #1;
        check_output("swp_rd_stall", o_stall, 1);
        tick();
        check_output("swp_rd_excl", o_exclusive, 1);
        check_output("swp_rd_we",   o_write_enable, 0);
        check_output("swp_rd_addr", o_address, 32'h300);
        i_ack = 1'b1;
        #1;
        check_output("swp_rd_ack", o_ack, 1);
        tick();
        i_ack = 1'b0;
        apply_stimulus(1, 1, 1, 1, 32'h300, 32'h66666666);
        #1;
        check_output("swp_wr_stall", o_stall, 1);
        check_output("swp_wr_empty", o_empty, 1);
        tick();
        check_output("swp_wr_we",   o_write_enable, 1);
        check_output("swp_wr_excl", o_exclusive, 1);
        check_output("swp_wr_data", o_write_data, 32'h66666666);
        check_output("swp_wr_empty_pt", o_empty, 1);
        i_ack = 1'b1;
        #1;
        check_output("swp_wr_ack", o_ack, 1);
        tick();
        i_ack = 1'b0;
        clear_core();
        #1;
        check_output("swp_empty", o_empty, 1);
        check_output("swp_count", 32'(dut.count), 0);

        // Sticky write error and clear priority
        apply_stimulus(1, 1, 0, 1, 32'h400, 32'h99999999);
        tick();
        clear_core();
        tick();
        check_output("werr_addr", o_address, 32'h400);
        check_output("werr_pre",  o_werr, 0);
        i_ack  = 1'b1;
        i_dabt = 1'b1;
        tick();
        i_ack  = 1'b0;
        i_dabt = 1'b0;
        check_output("werr_set", o_werr, 1);
        tick();
        tick();
        check_output("werr_sticky", o_werr, 1);
        i_werr_clr = 1'b1;
        tick();
        i_werr_clr = 1'b0;
        check_output("werr_clr", o_werr, 0);
        apply_stimulus(1, 1, 0, 1, 32'h404, 32'hAAAAAAAA);
        tick();
        clear_core();
        tick();
        i_ack      = 1'b1;
        i_dabt     = 1'b1;
        i_werr_clr = 1'b1;
        tick();
        i_ack      = 1'b0;
        i_dabt     = 1'b0;
        i_werr_clr = 1'b0;
        check_output("werr_set_wins", o_werr, 1);
        i_werr_clr = 1'b1;
        tick();
        i_werr_clr = 1'b0;
        check_output("werr_clr2", o_werr, 0);

        // Reset in the middle of a drain
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1, 1, 0, 1, 32'h500 + 32'(4 * k), 32'hBBBB0000 + 32'(k));
            tick();
        end
        clear_core();
        check_output("mrst_sel_pre",   o_select, 1);
        check_output("mrst_count_pre", 32'(dut.count), 3);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_output("mrst_sel",   o_select, 0);
        check_output("mrst_empty", o_empty, 1);
        check_output("mrst_count", 32'(dut.count), 0);
        apply_stimulus(1, 1, 0, 1, 32'h600, 32'hCCCCCCCC);
        #1;
        check_output("mrst_wr_ack",   o_ack, 1);
        check_output("mrst_wr_stall", o_stall, 0);
        tick();
        clear_core();
        check_output("mrst_wr_count", 32'(dut.count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
